// File: rtl/fwd_hazard_tracker_pkg.sv
// Shared types and constants for the forwarding/hazard tracker: entry layout,
// select encoding and stage indices.
package fwd_hazard_tracker_pkg;

  localparam int unsigned REG_AW_MAX = 8;
  localparam int unsigned FWD_SEL_RF = 0;

  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  // wsel is stored at REG_AW_MAX width with zero upper bits so one struct
  // serves every REG_AW instantiation.
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] wsel;
    logic                  regwrite;
    logic                  isload;
  } fwd_entry_t;

  function automatic int unsigned selw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source operand against all tracked producers;
// the youngest matching stage wins and may flag a load-use hazard.
module fwd_src_match
  import fwd_hazard_tracker_pkg::*;
#(
  parameter int          REG_AW    = 5,
  parameter int          FWD_DEPTH = 3,
  parameter int          LOAD_LAT  = 2,
  parameter int unsigned SELW      = 2
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              used_i,
  input  fwd_entry_t        entries_i [FWD_DEPTH],
  output logic [SELW-1:0]   sel_o,
  output logic              hazard_o
);

  logic found;

  always_comb begin
    sel_o    = SELW'(FWD_SEL_RF);
    hazard_o = 1'b0;
    found    = 1'b0;
    for (int unsigned k = 0; k < int'(FWD_DEPTH); k++) begin
      if (!found && used_i && (src_i != '0) &&
          entries_i[k].valid && entries_i[k].regwrite &&
          (entries_i[k].wsel == REG_AW_MAX'(src_i))) begin
        found = 1'b1;
        // A load whose data is not ready yet keeps the select on the RF.
        if (entries_i[k].isload && (k + 1 < int'(LOAD_LAT)))
          hazard_o = 1'b1;
        else
          sel_o = SELW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Shadow pipeline of in-flight register writes driving per-source forward
// selects, load-use stall detection and a saturating stall counter.
module fwd_hazard_tracker
  import fwd_hazard_tracker_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 2,
  parameter int CNT_W     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SRC*REG_AW-1:0]              iSrc,
  input  logic [NUM_SRC-1:0]                     iSrcUsed,
  input  logic                                   iDecValid,
  input  logic [REG_AW-1:0]                      iDecWsel,
  input  logic                                   iDecRegWrite,
  input  logic                                   iDecIsLoad,
  input  logic                                   iStallExt,
  input  logic                                   iFlush,
  output logic [NUM_SRC*selw(FWD_DEPTH)-1:0]     oFwdSel,
  output logic                                   oStall,
  output logic [CNT_W-1:0]                       oStallCnt
);

  localparam int unsigned SELW = selw(FWD_DEPTH);

  if (FWD_DEPTH < 1 || LOAD_LAT > FWD_DEPTH || REG_AW > int'(REG_AW_MAX)) begin : g_bad_params
    $error("fwd_hazard_tracker: illegal parameter combination");
  end

  fwd_entry_t       entries_q [FWD_DEPTH];
  fwd_entry_t       entries_d [FWD_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0] hazard;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SELW      (SELW)
    ) u_match (
      .src_i     (iSrc[s*REG_AW +: REG_AW]),
      .used_i    (iSrcUsed[s]),
      .entries_i (entries_q),
      .sel_o     (oFwdSel[s*SELW +: SELW]),
      .hazard_o  (hazard[s])
    );
  end

  assign oStall    = iDecValid && (|hazard);
  assign oStallCnt = cnt_q;

  always_comb begin
    entries_d = entries_q;
    cnt_d     = cnt_q;
    if (!iStallExt) begin
      for (int unsigned k = 1; k < int'(FWD_DEPTH); k++) begin
        entries_d[k] = entries_q[k-1];
        // The flushed EX instruction must not survive into MEM.
        if (iFlush && k == STG_MEM)
          entries_d[k].valid = 1'b0;
      end
      entries_d[STG_EX] = '0;
      if (iFlush) begin
        entries_d[STG_EX] = '0;
      end else if (oStall) begin
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end else begin
        entries_d[STG_EX].valid    = iDecValid;
        entries_d[STG_EX].wsel     = REG_AW_MAX'(iDecWsel);
        entries_d[STG_EX].regwrite = iDecRegWrite;
        entries_d[STG_EX].isload   = iDecIsLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < int'(FWD_DEPTH); k++)
        entries_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      entries_q <= entries_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Self-checking bench for fwd_hazard_tracker: directed vector table, hand
// sequences for stall/flush/reset corners, and random traffic vs a queue model.
module tb_fwd_hazard_tracker;

  localparam int REG_AW = 5, NUM_SRC = 2, FWD_DEPTH = 3, LOAD_LAT = 2, CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        iSrc;
  logic [1:0]        iSrcUsed;
  logic              iDecValid;
  logic [4:0]        iDecWsel;
  logic              iDecRegWrite, iDecIsLoad, iStallExt, iFlush;
  logic [3:0]        oFwdSel;
  logic              oStall;
  logic [CNT_W-1:0]  oStallCnt;

  int errors = 0;
  int checks = 0;

  fwd_hazard_tracker #(
    .REG_AW    (REG_AW),
    .NUM_SRC   (NUM_SRC),
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .iSrc         (iSrc),
    .iSrcUsed     (iSrcUsed),
    .iDecValid    (iDecValid),
    .iDecWsel     (iDecWsel),
    .iDecRegWrite (iDecRegWrite),
    .iDecIsLoad   (iDecIsLoad),
    .iStallExt    (iStallExt),
    .iFlush       (iFlush),
    .oFwdSel      (oFwdSel),
    .oStall       (oStall),
    .oStallCnt    (oStallCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  s0, s1;
    logic [1:0]  used;
    logic        dv;
    logic [4:0]  dw;
    logic        drw, dld, sx, fl;
    int unsigned e0, e1, est, ecnt;
  } vec_t;

  vec_t tbl [10];

  // Reference: youngest instruction at the front of the queue.
  typedef struct { bit v; bit [4:0] w; bit rw; bit ld; } minst_t;
  minst_t      pipe [$];
  int unsigned mcnt;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int unsigned e0, input int unsigned e1,
                            input int unsigned est, input int unsigned ecnt);
    check({tag, " sel0"},  int'(oFwdSel[1:0]), e0);
    check({tag, " sel1"},  int'(oFwdSel[3:2]), e1);
    check({tag, " stall"}, int'(oStall), est);
    check({tag, " cnt"},   int'(oStallCnt), ecnt);
  endtask

  task automatic set_in(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                        input logic dv, input logic [4:0] dw, input logic drw,
                        input logic dld, input logic sx, input logic fl);
    iSrc = {s1, s0}; iSrcUsed = used; iDecValid = dv; iDecWsel = dw;
    iDecRegWrite = drw; iDecIsLoad = dld; iStallExt = sx; iFlush = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  function automatic int unsigned model_sel(input logic [4:0] src, input logic used, output bit haz);
    haz = 0;
    if (!used || src == 0) return 0;
    foreach (pipe[k]) begin
      if (pipe[k].v && pipe[k].rw && pipe[k].w == src) begin
        // Load data exists only from stage LOAD_LAT-1 onward.
        if (pipe[k].ld && k < LOAD_LAT - 1) begin
          haz = 1;
          return 0;
        end
        return k + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    minst_t b = '{v: 0, w: 0, rw: 0, ld: 0};
    pipe.delete();
    repeat (FWD_DEPTH) pipe.push_back(b);
    mcnt = 0;
  endtask

  task automatic model_advance(input bit stall);
    minst_t b = '{v: 0, w: 0, rw: 0, ld: 0};
    minst_t d;
    if (iStallExt) return;
    if (iFlush) begin
      pipe[0].v = 0;
      pipe.push_front(b);
    end else if (stall) begin
      pipe.push_front(b);
      if (mcnt < 65535) mcnt++;
    end else begin
      d = '{v: iDecValid, w: iDecWsel, rw: iDecRegWrite, ld: iDecIsLoad};
      pipe.push_front(d);
    end
    void'(pipe.pop_back());
  endtask

  initial begin
    bit          h0, h1;
    int unsigned m0, m1, mst;

    tbl[0] = '{5'd1, 5'd2, 2'b11, 1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{5'd3, 5'd0, 2'b01, 1, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{5'd3, 5'd0, 2'b01, 1, 5'd3, 1, 0, 0, 0, 2, 0, 0, 0};
    tbl[3] = '{5'd0, 5'd3, 2'b10, 1, 5'd3, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[4] = '{5'd0, 5'd3, 2'b10, 1, 5'd5, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{5'd5, 5'd3, 2'b11, 1, 5'd6, 1, 0, 0, 0, 0, 2, 1, 0};
    tbl[6] = '{5'd5, 5'd3, 2'b11, 1, 5'd6, 1, 0, 0, 0, 2, 3, 0, 1};
    tbl[7] = '{5'd6, 5'd0, 2'b10, 1, 5'd0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[8] = '{5'd0, 5'd6, 2'b11, 0, 5'd0, 0, 0, 0, 0, 0, 2, 0, 1};
    tbl[9] = '{5'd6, 5'd0, 2'b01, 0, 5'd0, 0, 0, 0, 0, 3, 0, 0, 1};

    @(negedge clk);
    do_reset();
    set_in(5'd3, 5'd3, 2'b11, 1, 5'd0, 0, 0, 0, 0);
    #4 check_outs("reset", 0, 0, 0, 0);
    @(posedge clk); #1;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].s0, tbl[i].s1, tbl[i].used, tbl[i].dv, tbl[i].dw,
             tbl[i].drw, tbl[i].dld, tbl[i].sx, tbl[i].fl);
      #4 check_outs($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].est, tbl[i].ecnt);
      tick();
    end

    // Load-use stall held by an external freeze.
    do_reset();
    set_in(0, 0, 2'b00, 1, 5'd5, 1, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd5, 0, 2'b01, 1, 5'd6, 1, 0, 1, 0);
      #4 check_outs($sformatf("frz%0d", i), 0, 0, 1, 0);
      tick();
    end
    set_in(5'd5, 0, 2'b01, 1, 5'd6, 1, 0, 0, 0);
    #4 check_outs("frz_rel", 0, 0, 1, 0);
    tick();
    #4 check_outs("frz_after", 2, 0, 0, 1);
    tick();

    // Reset overrides flush and freeze mid-stream.
    rst = 1'b1;
    set_in(5'd5, 5'd6, 2'b11, 1, 5'd6, 1, 1, 1, 1);
    tick();
    rst = 1'b0;
    set_in(5'd5, 5'd6, 2'b11, 1, 5'd7, 1, 0, 0, 0);
    #4 check_outs("midrst", 0, 0, 0, 0);
    tick();

    // Flush kills a load in EX while decode would have stalled on it.
    do_reset();
    set_in(0, 0, 2'b00, 1, 5'd7, 1, 0, 0, 0);
    tick();
    set_in(0, 0, 2'b00, 1, 5'd5, 1, 1, 0, 0);
    tick();
    set_in(5'd5, 0, 2'b01, 1, 5'd8, 1, 0, 0, 1);
    #4 check_outs("flush", 0, 0, 1, 0);
    tick();
    set_in(5'd5, 5'd7, 2'b11, 1, 5'd8, 1, 0, 0, 0);
    #4 check_outs("post_flush", 0, 3, 0, 0);
    tick();

    // Random traffic against the queue model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
             1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0));
      #4;
      m0  = model_sel(iSrc[4:0], iSrcUsed[0], h0);
      m1  = model_sel(iSrc[9:5], iSrcUsed[1], h1);
      mst = int'(iDecValid && (h0 || h1));
      check_outs($sformatf("rnd%0d", i), m0, m1, mst, mcnt);
      model_advance(mst != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Parametrised successor to the two-source, two-stage forwarding unit.
- Tracks in-flight register writes in an internal shadow pipeline of FWD_DEPTH stages.
- Produces per-source forward selects with youngest-producer priority, plus load-use stall detection and a saturating stall counter.
- Sits beside the decode stage; the datapath muxes use oFwdSel, and the PC/IF-ID registers use oStall.

Parameters:
- REG_AW, 5: register index width.
- NUM_SRC, 2: number of source operands checked per instruction.
- FWD_DEPTH, 3: tracked producer stages after decode (stage 0 = EX, 1 = MEM, 2 = WB).
- LOAD_LAT, 2: a load's result is forwardable only from stage index >= LOAD_LAT-1. With the default, a load in EX stalls and a load in MEM forwards.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: clock. Single clock domain, all state on rising edge.
- rst, input, 1: synchronous, active-high reset.
- iSrc, input, NUM_SRC*REG_AW: decode-stage source register indices; source s occupies bits [s*REG_AW +: REG_AW].
- iSrcUsed, input, NUM_SRC: per-source "operand actually read" flag.
- iDecValid, input, 1: decode slot holds a real instruction.
- iDecWsel, input, REG_AW: decode-stage destination register index.
- iDecRegWrite, input, 1: decode instruction writes the register file.
- iDecIsLoad, input, 1: decode instruction is a load.
- iStallExt, input, 1: external freeze (cache miss); the whole pipeline holds.
- iFlush, input, 1: kill decode and EX (branch redirect).
- oFwdSel, output, NUM_SRC*SELW: per-source select, SELW = clog2(FWD_DEPTH+1). 0 = register file; k+1 = stage k.
- oStall, output, 1: load-use hazard; hold PC and IF/ID, inject a bubble.
- oStallCnt, output, CNT_W: number of cycles with oStall=1, saturating.

Behaviour:
- State: FWD_DEPTH entries {valid, wsel, regwrite, isload}.
- Reset: all entries valid=0, oStallCnt=0, so oStall=0 and oFwdSel=0 in the cycle after reset.
- Reset dominates iFlush and iStallExt.
- Match: source s matches stage k when all hold:
  - iSrcUsed[s]
  - iSrc[s] != 0
  - entry[k].valid and entry[k].regwrite
  - entry[k].wsel == iSrc[s]
- Priority: the lowest k (youngest producer) wins. With no match, the select is 0.
- Hazard: the winning stage k for source s has isload=1 and k < LOAD_LAT-1.
  - That source's select is forced to 0.
  - oStall = iDecValid AND (any source hazard).
- oFwdSel and oStall are combinational from state and inputs, so zero latency.
- Advance, in priority order:
  - iStallExt=1: all entries hold. oStallCnt does not count, even if oStall=1.
  - iFlush=1: shift entries up by one; entry[0] receives a bubble (valid=0). The killed EX entry is not shifted into stage 1; stage 1 becomes invalid.
  - oStall=1: shift entries up; entry[0] receives a bubble; oStallCnt += 1, saturating at all-ones.
  - Otherwise: shift entries up; entry[0] receives {iDecValid, iDecWsel, iDecRegWrite, iDecIsLoad}.
- The oldest entry (FWD_DEPTH-1) is discarded on shift.
- A write to r0 is tracked but never matched, because sources equal to 0 are excluded.
- Simultaneous iFlush and oStall: flush wins and the counter does not increment.
- No handshake beyond these level signals. Illegal parameters (FWD_DEPTH < 1, LOAD_LAT > FWD_DEPTH) fail an elaboration-time check.

Decomposition:
- Shared package (pipeline package):
  - SELW function/constant
  - FWD_SEL_RF = 0 constant
  - tracker-entry struct typedef {valid, wsel, regwrite, isload}
  - stage index constants EX/MEM/WB
- One sub-module, fwd_src_match: priority match for one source over all entries, returning {sel, hazard}. Instantiated NUM_SRC times by a generate loop.

Test Plan (defaults):
1. add r3 issued, next cycle decode reads r3 as src0 -> oFwdSel[src0]=1 (EX), oStall=0. One cycle later with an intervening nop -> sel=2 (MEM).
2. r3 written by EX and by MEM simultaneously, src1=r3 -> sel=1 (youngest wins).
3. lw r5 then add using r5 -> cycle 1: oStall=1, sel=0, bubble enters EX. Cycle 2: oStall=0, sel=2, oStallCnt=1.
4. Load-use stall coinciding with iStallExt=1 for 3 cycles -> entries frozen, oStall held at 1, oStallCnt unchanged until release, then +1.
5. iFlush with lw r5 in EX and decode reading r5 -> next cycle stages 0 and 1 invalid, no stall, oStallCnt unchanged.
6. Source r0 with a producer writing r0; iSrcUsed=0 on a matching register -> sel=0, oStall=0. Then rst mid-stream -> all selects 0, counter 0.
